// File: rtl/noc_vc_arbiter_pkg.sv
// Shared constants and types for the two-VC output link arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package noc_vc_arbiter_pkg;

  localparam int Noc_Data_Width = 32;
  localparam int Noc_VC_Channel = 2;

  // Arbiter FSM encodings
  localparam logic [0:0] NOC_ARB_IDLE   = 1'b0;
  localparam logic [0:0] NOC_ARB_LOCKED = 1'b1;

  typedef logic [Noc_Data_Width-1:0] flit_t;

  // One-hot request/grant vector for a VC index.
  function automatic logic [1:0] vc_onehot(input logic vc);
    return vc ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/noc_vc_arbiter_if.sv
// Bundle of the two VC input streams and the merged link output.
// Latency: n/a (wires only).
// Backpressure: receive_ready per VC, sender_ready and per-VC VCready from the link.
// Modports: master = router side (drives VC streams, link ready),
//           slave  = arbiter side (drives receive_ready and sender_*).
interface noc_vc_arbiter_if;
  import noc_vc_arbiter_pkg::*;

  logic                      Noc_channel0_receive_valid;
  flit_t                     Noc_channel0_receive_flit;
  logic                      Noc_channel0_receive_is_header;
  logic                      Noc_channel0_receive_is_tail;
  logic                      Noc_channel0_receive_ready;

  logic                      Noc_channel1_receive_valid;
  flit_t                     Noc_channel1_receive_flit;
  logic                      Noc_channel1_receive_is_header;
  logic                      Noc_channel1_receive_is_tail;
  logic                      Noc_channel1_receive_ready;

  logic                      Noc_sender_valid;
  flit_t                     Noc_sender_flit;
  logic                      Noc_sender_is_header;
  logic                      Noc_sender_is_tail;
  logic                      Noc_sender_vc_id;
  logic                      Noc_sender_ready;
  logic [Noc_VC_Channel-1:0] Noc_sender_VCready;

  modport master (
    output Noc_channel0_receive_valid, Noc_channel0_receive_flit,
           Noc_channel0_receive_is_header, Noc_channel0_receive_is_tail,
    input  Noc_channel0_receive_ready,
    output Noc_channel1_receive_valid, Noc_channel1_receive_flit,
           Noc_channel1_receive_is_header, Noc_channel1_receive_is_tail,
    input  Noc_channel1_receive_ready,
    input  Noc_sender_valid, Noc_sender_flit, Noc_sender_is_header,
           Noc_sender_is_tail, Noc_sender_vc_id,
    output Noc_sender_ready, Noc_sender_VCready
  );

  modport slave (
    input  Noc_channel0_receive_valid, Noc_channel0_receive_flit,
           Noc_channel0_receive_is_header, Noc_channel0_receive_is_tail,
    output Noc_channel0_receive_ready,
    input  Noc_channel1_receive_valid, Noc_channel1_receive_flit,
           Noc_channel1_receive_is_header, Noc_channel1_receive_is_tail,
    output Noc_channel1_receive_ready,
    output Noc_sender_valid, Noc_sender_flit, Noc_sender_is_header,
           Noc_sender_is_tail, Noc_sender_vc_id,
    input  Noc_sender_ready, Noc_sender_VCready
  );

endinterface

// File: rtl/noc_rr_arbiter2.sv
// Two-requester round-robin arbiter, one-hot grant, pointer advanced on update.
// Latency: grant is combinational from req_i and the pointer; pointer moves at the next edge.
// Backpressure: none; caller decides when a grant was consumed via update_i.
// Ports: clk_i/rst_ni clock and async active-low reset; req_i requests; update_i with
//        last_i (index of the requester just served) moves priority to the other one;
//        gnt_o one-hot grant.
module noc_rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // ptr_q names the requester that wins a tie.
  logic ptr_q, ptr_d;

  always_comb begin
    if (req_i == 2'b11) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
  end

  assign ptr_d = update_i ? ~last_i : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/noc_vc_arbiter.sv
// Packet-granular merge of two VC flit streams onto one link, tagging each flit with its VC.
// Latency: 0 (combinational pass-through); 1 with NOC_VC_ARB_OUTREG_EN defined.
// Backpressure: only the granted/owner VC sees ready, following link readiness.
// Ports: noc_clk, noc_rst_n (async active-low); bus = noc_vc_arbiter_if.slave carrying
//        both VC receive streams, the merged sender stream, sender_ready and VCready.
// Build option: NOC_VC_ARB_OUTREG_EN inserts a one-entry output register.
module noc_vc_arbiter
  import noc_vc_arbiter_pkg::*;
(
  input logic             noc_clk,
  input logic             noc_rst_n,
  noc_vc_arbiter_if.slave bus
);

  logic [0:0] state_q, state_d;
  logic       owner_q, owner_d;
  // Set for the single cycle after a multi-flit packet's tail: no new grant
  // is issued then, so every packet boundary out of a lock costs one bubble.
  logic       gap_q, gap_d;

  logic [1:0] in_vld, in_hdr, in_tail;
  logic [1:0] elig, rr_gnt, gnt;
  logic       arb_open, gnt_vc, rr_update;
  logic       sel_vld, sel_hdr, sel_tail;
  flit_t      sel_flit;
  logic       out_accept, hs;

  assign in_vld  = {bus.Noc_channel1_receive_valid,     bus.Noc_channel0_receive_valid};
  assign in_hdr  = {bus.Noc_channel1_receive_is_header, bus.Noc_channel0_receive_is_header};
  assign in_tail = {bus.Noc_channel1_receive_is_tail,   bus.Noc_channel0_receive_is_tail};

  assign arb_open = (state_q == NOC_ARB_IDLE) && !gap_q;
  assign elig     = in_vld & in_hdr & bus.Noc_sender_VCready & {2{arb_open}};

  noc_rr_arbiter2 u_rr (
    .clk_i    (noc_clk),
    .rst_ni   (noc_rst_n),
    .req_i    (elig),
    .update_i (rr_update),
    .last_i   (gnt_vc),
    .gnt_o    (rr_gnt)
  );

  // While locked the owner keeps the link regardless of VCready.
  assign gnt    = (state_q == NOC_ARB_LOCKED) ? vc_onehot(owner_q) : rr_gnt;
  assign gnt_vc = gnt[1];

  always_comb begin
    sel_vld  = 1'b0;
    sel_hdr  = 1'b0;
    sel_tail = 1'b0;
    sel_flit = '0;
    if (gnt[1]) begin
      sel_vld  = in_vld[1];
      sel_hdr  = in_hdr[1];
      sel_tail = in_tail[1];
      sel_flit = bus.Noc_channel1_receive_flit;
    end else if (gnt[0]) begin
      sel_vld  = in_vld[0];
      sel_hdr  = in_hdr[0];
      sel_tail = in_tail[0];
      sel_flit = bus.Noc_channel0_receive_flit;
    end
  end

  assign hs = sel_vld && out_accept;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    gap_d     = 1'b0;
    rr_update = 1'b0;
    if (state_q == NOC_ARB_IDLE) begin
      if (hs) begin
        if (sel_tail) begin
          rr_update = 1'b1;          // single-flit packet: stay idle
        end else begin
          state_d = NOC_ARB_LOCKED;
          owner_d = gnt_vc;
        end
      end
    end else if (hs && sel_tail) begin
      state_d   = NOC_ARB_IDLE;
      rr_update = 1'b1;
      gap_d     = 1'b1;
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q <= NOC_ARB_IDLE;
      owner_q <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gap_q   <= gap_d;
    end
  end

  // Readies are gated by reset so an upstream that stays live during reset
  // never sees a flit consumed.
  assign bus.Noc_channel0_receive_ready = noc_rst_n && gnt[0] && out_accept;
  assign bus.Noc_channel1_receive_ready = noc_rst_n && gnt[1] && out_accept;

`ifdef NOC_VC_ARB_OUTREG_EN
  logic  out_vld_q,  out_vld_d;
  logic  out_hdr_q,  out_hdr_d;
  logic  out_tail_q, out_tail_d;
  logic  out_vc_q,   out_vc_d;
  flit_t out_flit_q, out_flit_d;

  assign out_accept = !out_vld_q || bus.Noc_sender_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_hdr_d  = out_hdr_q;
    out_tail_d = out_tail_q;
    out_vc_d   = out_vc_q;
    out_flit_d = out_flit_q;
    if (hs) begin
      out_vld_d  = 1'b1;
      out_hdr_d  = sel_hdr;
      out_tail_d = sel_tail;
      out_vc_d   = gnt_vc;
      out_flit_d = sel_flit;
    end else if (bus.Noc_sender_ready) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      out_vld_q  <= 1'b0;
      out_hdr_q  <= 1'b0;
      out_tail_q <= 1'b0;
      out_vc_q   <= 1'b0;
      out_flit_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_hdr_q  <= out_hdr_d;
      out_tail_q <= out_tail_d;
      out_vc_q   <= out_vc_d;
      out_flit_q <= out_flit_d;
    end
  end

  assign bus.Noc_sender_valid     = out_vld_q;
  assign bus.Noc_sender_flit      = out_flit_q;
  assign bus.Noc_sender_is_header = out_hdr_q;
  assign bus.Noc_sender_is_tail   = out_tail_q;
  assign bus.Noc_sender_vc_id     = out_vc_q;
`else
  assign out_accept = bus.Noc_sender_ready;

  // Pass-through path; forced quiet while reset is held.
  assign bus.Noc_sender_valid     = noc_rst_n && sel_vld;
  assign bus.Noc_sender_flit      = noc_rst_n ? sel_flit : '0;
  assign bus.Noc_sender_is_header = noc_rst_n && sel_hdr;
  assign bus.Noc_sender_is_tail   = noc_rst_n && sel_tail;
  assign bus.Noc_sender_vc_id     = noc_rst_n && gnt_vc;
`endif

endmodule

// File: tb/tb_noc_vc_arbiter.sv
// Bench for noc_vc_arbiter (default pass-through build): directed scenarios with literal
// expectations plus a randomized phase, all checked each cycle against a packet-level model.
module tb_noc_vc_arbiter;
  import noc_vc_arbiter_pkg::*;

  typedef struct packed {
    logic [31:0] flit;
    logic        hdr;
    logic        tail;
  } sflit_t;

  logic noc_clk = 1'b0;
  logic noc_rst_n = 1'b0;
  always #5 noc_clk = ~noc_clk;

  noc_vc_arbiter_if bus ();
  noc_vc_arbiter dut (.noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  sflit_t q0[$];
  sflit_t q1[$];
  int gen_seq[2];
  int exp_seq[2];
  logic [1:0] resync;
  logic [1:0] pres, acc, ven, vcr_k;
  logic       sready_k;

  // Model state: owner of the link (-1 = none), tie-break VC, and the
  // post-packet bubble.
  int  m_owner, m_prio;
  bit  m_gap;

  int log_vc[$];
  int log_cyc[$];
  bit log_hdr[$];
  bit log_tail[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_pkt(input int vc, input int len);
    for (int k = 0; k < len; k++) begin
      sflit_t f;
      logic [15:0] s;
      s = 16'(gen_seq[vc]);
      f.flit = {vc[0], 15'd0, s};
      f.hdr  = (k == 0);
      f.tail = (k == len - 1);
      if (vc == 0) q0.push_back(f);
      else q1.push_back(f);
      gen_seq[vc]++;
    end
  endtask

  task automatic drive_phase();
    @(posedge noc_clk);
    #1;
    cyc++;
    if (acc[0]) begin q0.delete(0); pres[0] = 1'b0; end
    if (acc[1]) begin q1.delete(0); pres[1] = 1'b0; end
    if (!pres[0] && ven[0] && q0.size() > 0) pres[0] = 1'b1;
    if (!pres[1] && ven[1] && q1.size() > 0) pres[1] = 1'b1;
    bus.Noc_channel0_receive_valid     = pres[0];
    bus.Noc_channel0_receive_flit      = pres[0] ? q0[0].flit : 32'd0;
    bus.Noc_channel0_receive_is_header = pres[0] ? q0[0].hdr  : 1'b0;
    bus.Noc_channel0_receive_is_tail   = pres[0] ? q0[0].tail : 1'b0;
    bus.Noc_channel1_receive_valid     = pres[1];
    bus.Noc_channel1_receive_flit      = pres[1] ? q1[0].flit : 32'd0;
    bus.Noc_channel1_receive_is_header = pres[1] ? q1[0].hdr  : 1'b0;
    bus.Noc_channel1_receive_is_tail   = pres[1] ? q1[0].tail : 1'b0;
    bus.Noc_sender_ready   = sready_k;
    bus.Noc_sender_VCready = vcr_k;
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  task automatic check_cycle();
    logic [1:0] v, h, t, vr;
    logic [31:0] f0, f1, ef;
    logic sr, ev, eh, et, hs;
    int g;
    bit new_gap;
    v  = {bus.Noc_channel1_receive_valid, bus.Noc_channel0_receive_valid};
    h  = {bus.Noc_channel1_receive_is_header, bus.Noc_channel0_receive_is_header};
    t  = {bus.Noc_channel1_receive_is_tail, bus.Noc_channel0_receive_is_tail};
    f0 = bus.Noc_channel0_receive_flit;
    f1 = bus.Noc_channel1_receive_flit;
    vr = bus.Noc_sender_VCready;
    sr = bus.Noc_sender_ready;
    if (!noc_rst_n) begin
      chk("rst_sender_valid", 64'(bus.Noc_sender_valid), 0);
      chk("rst_sender_flit", 64'(bus.Noc_sender_flit), 0);
      chk("rst_sender_hdr", 64'(bus.Noc_sender_is_header), 0);
      chk("rst_sender_tail", 64'(bus.Noc_sender_is_tail), 0);
      chk("rst_vc_id", 64'(bus.Noc_sender_vc_id), 0);
      chk("rst_ready0", 64'(bus.Noc_channel0_receive_ready), 0);
      chk("rst_ready1", 64'(bus.Noc_channel1_receive_ready), 0);
      m_owner = -1; m_prio = 0; m_gap = 0;
      acc = 2'b00; resync = 2'b11;
      return;
    end
    g = -1;
    if (m_owner >= 0) g = m_owner;
    else if (!m_gap) begin
      bit e0, e1;
      e0 = v[0] && h[0] && vr[0];
      e1 = v[1] && h[1] && vr[1];
      if (e0 && e1) g = m_prio;
      else if (e0) g = 0;
      else if (e1) g = 1;
    end
    ev = (g >= 0) ? v[g] : 1'b0;
    eh = (g >= 0) ? h[g] : 1'b0;
    et = (g >= 0) ? t[g] : 1'b0;
    ef = (g == 1) ? f1 : ((g == 0) ? f0 : 32'd0);
    chk("sender_valid", 64'(bus.Noc_sender_valid), 64'(ev));
    chk("sender_flit", 64'(bus.Noc_sender_flit), 64'(ef));
    chk("sender_hdr", 64'(bus.Noc_sender_is_header), 64'(eh));
    chk("sender_tail", 64'(bus.Noc_sender_is_tail), 64'(et));
    chk("sender_vc_id", 64'(bus.Noc_sender_vc_id), 64'((g == 1) ? 1 : 0));
    chk("ready0", 64'(bus.Noc_channel0_receive_ready), 64'((g == 0) && sr));
    chk("ready1", 64'(bus.Noc_channel1_receive_ready), 64'((g == 1) && sr));
    hs = (g >= 0) && v[g] && sr;
    acc = 2'b00;
    new_gap = 0;
    if (hs) begin
      acc[g] = 1'b1;
      log_vc.push_back(g);
      log_cyc.push_back(cyc);
      log_hdr.push_back(h[g]);
      log_tail.push_back(t[g]);
      if (resync[g]) begin
        exp_seq[g] = int'(ef[15:0]);
        resync[g] = 1'b0;
        chk("first_after_reset_is_header", 64'(h[g]), 1);
      end
      chk("in_order_seq", 64'(ef[15:0]), 64'(16'(exp_seq[g])));
      exp_seq[g]++;
      if (m_owner < 0) begin
        if (t[g]) m_prio = 1 - g;
        else m_owner = g;
      end else if (t[g]) begin
        m_owner = -1;
        m_prio = 1 - g;
        new_gap = 1;
      end
    end
    m_gap = new_gap;
  endtask

  task automatic step();
    drive_phase();
    @(negedge noc_clk);
    check_cycle();
  endtask

  task automatic run_until(input string name, input int n, input int maxc);
    int k = 0;
    while (log_vc.size() < n && k < maxc) begin
      step();
      k++;
    end
    chk(name, 64'(log_vc.size() >= n), 1);
  endtask

  task automatic do_reset();
    noc_rst_n = 1'b0;
    q0.delete(); q1.delete(); pres = 2'b00;
    repeat (2) step();
    #1 noc_rst_n = 1'b1;
  endtask

  initial begin
    int base, c0;
    int e3[6];
    gen_seq[0] = 0; gen_seq[1] = 0; exp_seq[0] = 0; exp_seq[1] = 0;
    resync = 2'b11; pres = 2'b00; acc = 2'b00; ven = 2'b00;
    vcr_k = 2'b11; sready_k = 1'b1;
    m_owner = -1; m_prio = 0; m_gap = 0;
    bus.Noc_channel0_receive_valid = 0; bus.Noc_channel0_receive_flit = '0;
    bus.Noc_channel0_receive_is_header = 0; bus.Noc_channel0_receive_is_tail = 0;
    bus.Noc_channel1_receive_valid = 0; bus.Noc_channel1_receive_flit = '0;
    bus.Noc_channel1_receive_is_header = 0; bus.Noc_channel1_receive_is_tail = 0;
    bus.Noc_sender_ready = 1; bus.Noc_sender_VCready = 2'b11;

    // Reset state
    repeat (3) step();
    chk("reset_valid_lit", 64'(bus.Noc_sender_valid), 0);
    chk("reset_vcid_lit", 64'(bus.Noc_sender_vc_id), 0);
    #1 noc_rst_n = 1'b1;

    // Both VCs with 3-flit packets right after reset: VC0, bubble, VC1
    push_pkt(0, 3); push_pkt(1, 3); ven = 2'b11;
    base = log_vc.size();
    run_until("t3_timeout", base + 6, 30);
    e3 = '{0, 0, 0, 1, 1, 1};
    for (int k = 0; k < 6; k++) chk("t3_vc_order", 64'(log_vc[base + k]), 64'(e3[k]));
    chk("t3_vc0_back_to_back", 64'(log_cyc[base + 2] - log_cyc[base]), 2);
    chk("t3_bubble", 64'(log_cyc[base + 3] - log_cyc[base + 2]), 2);
    ven = 2'b00;
    repeat (3) step();

    // VC0 4-flit packet alone
    push_pkt(0, 4); ven = 2'b01;
    base = log_vc.size();
    run_until("t2_timeout", base + 4, 20);
    chk("t2_consecutive", 64'(log_cyc[base + 3] - log_cyc[base]), 3);
    chk("t2_hdr_first", 64'(log_hdr[base]), 1);
    chk("t2_tail_last", 64'(log_tail[base + 3]), 1);
    chk("t2_vc_last", 64'(log_vc[base + 3]), 0);
    ven = 2'b00;
    repeat (3) step();
    // Pointer now favours VC1
    push_pkt(0, 1); push_pkt(1, 1); ven = 2'b11;
    base = log_vc.size();
    run_until("t2b_timeout", base + 2, 10);
    chk("t2b_ptr_vc1_first", 64'(log_vc[base]), 1);
    chk("t2b_then_vc0", 64'(log_vc[base + 1]), 0);
    ven = 2'b00;
    repeat (2) step();

    // Alternating single-flit packets after reset: 0,1,0,1 back to back
    do_reset();
    push_pkt(0, 1); push_pkt(0, 1); push_pkt(1, 1); push_pkt(1, 1); ven = 2'b11;
    base = log_vc.size();
    run_until("t5_timeout", base + 4, 12);
    chk("t5_seq0", 64'(log_vc[base]), 0);
    chk("t5_seq1", 64'(log_vc[base + 1]), 1);
    chk("t5_seq2", 64'(log_vc[base + 2]), 0);
    chk("t5_seq3", 64'(log_vc[base + 3]), 1);
    chk("t5_no_lock_gap", 64'(log_cyc[base + 3] - log_cyc[base]), 3);
    ven = 2'b00;
    repeat (2) step();

    // VC1 blocked by VCready, then released
    push_pkt(1, 1); ven = 2'b10; vcr_k = 2'b01;
    base = log_vc.size();
    repeat (5) step();
    chk("t4_not_granted", 64'(log_vc.size() - base), 0);
    chk("t4_ready1_low", 64'(bus.Noc_channel1_receive_ready), 0);
    vcr_k = 2'b11;
    c0 = cyc;
    run_until("t4_timeout", base + 1, 4);
    chk("t4_vc1", 64'(log_vc[base]), 1);
    chk("t4_grant_cycle", 64'(log_cyc[base] - c0), 1);
    ven = 2'b00;
    repeat (2) step();

    // sender_ready toggling mid-packet
    push_pkt(0, 4); ven = 2'b01;
    base = log_vc.size();
    for (int k = 0; k < 20 && log_vc.size() < base + 4; k++) begin
      sready_k = (k % 2 == 0);
      step();
    end
    sready_k = 1'b1;
    repeat (3) step();
    chk("t6_exactly_four", 64'(log_vc.size() - base), 4);
    chk("t6_hdr_first", 64'(log_hdr[base]), 1);
    chk("t6_tail_last", 64'(log_tail[base + 3]), 1);
    ven = 2'b00;

    // Reset in the middle of a locked packet
    push_pkt(0, 4); ven = 2'b01;
    base = log_vc.size();
    run_until("t7_timeout", base + 2, 10);
    drive_phase();
    #1 noc_rst_n = 1'b0;
    #1;
    chk("t7_valid_zero", 64'(bus.Noc_sender_valid), 0);
    chk("t7_flit_zero", 64'(bus.Noc_sender_flit), 0);
    chk("t7_ready0_zero", 64'(bus.Noc_channel0_receive_ready), 0);
    chk("t7_vcid_zero", 64'(bus.Noc_sender_vc_id), 0);
    @(negedge noc_clk);
    check_cycle();
    do_reset();
    push_pkt(1, 1); push_pkt(0, 2); ven = 2'b11;
    base = log_vc.size();
    run_until("t7b_timeout", base + 3, 12);
    chk("t7_vc0_first", 64'(log_vc[base]), 0);
    chk("t7_vc0_hdr", 64'(log_hdr[base]), 1);
    chk("t7_vc1_after", 64'(log_vc[base + 2]), 1);
    ven = 2'b00;
    repeat (2) step();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) == 0) push_pkt(0, $urandom_range(1, 4));
      if (q1.size() == 0 && $urandom_range(0, 3) == 0) push_pkt(1, $urandom_range(1, 4));
      ven = 2'($urandom);
      sready_k = ($urandom_range(0, 3) != 0);
      vcr_k = {1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0)};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
